// File: rtl/ritc_align_pkg.sv
// Shared state encoding, field widths and lane-word helper for the RITC
// bit-lane alignment controller.
package ritc_align_pkg;

  localparam int SLIP_CNT_W = 4;
  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'h0F;

  // Upper bounds for the generic lane-word extractor below.
  localparam int LANE_BUS_MAX  = 256;
  localparam int LANE_WORD_MAX = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } align_state_e;

  // Returns lane 'lane' of a packed bus of word_w-bit lanes, zero-extended.
  function automatic logic [LANE_WORD_MAX-1:0] lane_word(
    input logic [LANE_BUS_MAX-1:0] bus,
    input int                      lane,
    input int                      word_w
  );
    logic [LANE_WORD_MAX-1:0] mask;
    mask = LANE_WORD_MAX'((33'd1 << word_w) - 33'd1);
    return LANE_WORD_MAX'(bus >> (lane * word_w)) & mask;
  endfunction

endpackage

// File: rtl/ritc_lane_matcher.sv
// Registered lane-select mux and training-pattern comparator; match_o lags
// data_i by one clock.
module ritc_lane_matcher
  import ritc_align_pkg::*;
#(
  parameter int               NBITS         = 12,
  parameter int               WORD          = 8,
  parameter int               LANE_W        = 4,
  parameter logic [WORD-1:0]  TRAIN_PATTERN = WORD'(TRAIN_PATTERN_DEF)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NBITS*WORD-1:0]  data_i,
  input  logic [LANE_W-1:0]      lane_sel_i,
  output logic                   match_o
);

  logic [LANE_WORD_MAX-1:0] word_d;
  logic [LANE_WORD_MAX-1:0] word_q;

  always_comb begin
    word_d = lane_word(LANE_BUS_MAX'(data_i), int'(lane_sel_i), WORD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign match_o = (word_q == LANE_WORD_MAX'(TRAIN_PATTERN));

endmodule

// File: rtl/ritc_bitslip_align.sv
// Per-channel RITC lane aligner: walks the lanes, pulses ISERDES bitslip
// until each lane shows the training pattern, and reports lock and slip counts.
//
// state  | meaning
// IDLE   | waiting for start_i
// SETTLE | letting a lane/slip change propagate; data ignored
// CHECK  | counting consecutive pattern matches on the current lane
// SLIP   | one-cycle bitslip pulse to the current lane
// NEXT   | advance to the next lane or finish
// DONE   | one-cycle completion pulse
module ritc_bitslip_align
  import ritc_align_pkg::*;
#(
  parameter int               NBITS         = 12,
  parameter int               WORD          = 8,
  parameter logic [WORD-1:0]  TRAIN_PATTERN = WORD'(TRAIN_PATTERN_DEF),
  parameter int               MATCH_CYCLES  = 16,
  parameter int               SLIP_WAIT     = 4,
  parameter int               MAX_SLIPS     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NBITS*WORD-1:0]        data_i,
  input  logic                         start_i,
  output logic [NBITS-1:0]             bitslip_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NBITS-1:0]             lane_ok_o,
  output logic                         aligned_o,
  output logic [NBITS*SLIP_CNT_W-1:0]  slip_count_o
);

  localparam int LANE_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int MATCH_W = $clog2(MATCH_CYCLES + 1);

  align_state_e                         state_q, state_d;
  logic [LANE_W-1:0]                    lane_q, lane_d;
  logic [WAIT_W-1:0]                    wait_q, wait_d;
  logic [MATCH_W-1:0]                   match_cnt_q, match_cnt_d;
  logic [NBITS-1:0]                     lane_ok_q, lane_ok_d;
  logic [NBITS-1:0][SLIP_CNT_W-1:0]     slip_cnt_q, slip_cnt_d;
  logic                                 aligned_q, aligned_d;

  logic                                 lane_match;
  logic [SLIP_CNT_W-1:0]                cur_slips;

  ritc_lane_matcher #(
    .NBITS         (NBITS),
    .WORD          (WORD),
    .LANE_W        (LANE_W),
    .TRAIN_PATTERN (TRAIN_PATTERN)
  ) u_matcher (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .lane_sel_i (lane_q),
    .match_o    (lane_match)
  );

  assign cur_slips = slip_cnt_q[lane_q];

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    wait_d      = wait_q;
    match_cnt_d = match_cnt_q;
    lane_ok_d   = lane_ok_q;
    slip_cnt_d  = slip_cnt_q;
    aligned_d   = aligned_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lane_ok_d  = '0;
          slip_cnt_d = '0;
          aligned_d  = 1'b0;
          lane_d     = '0;
          wait_d     = WAIT_W'(SLIP_WAIT);
          state_d    = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) begin
          match_cnt_d = '0;
          state_d     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (lane_match) begin
          if (match_cnt_q == MATCH_W'(MATCH_CYCLES - 1)) begin
            lane_ok_d[lane_q] = 1'b1;
            state_d           = ST_NEXT;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
          end
        end else begin
          match_cnt_d = '0;
          // Out of slips: the lane is left unlocked.
          if (cur_slips < SLIP_CNT_W'(MAX_SLIPS)) begin
            state_d = ST_SLIP;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end

      ST_SLIP: begin
        if (cur_slips < SLIP_CNT_W'(MAX_SLIPS)) begin
          slip_cnt_d[lane_q] = cur_slips + SLIP_CNT_W'(1);
        end
        wait_d  = WAIT_W'(SLIP_WAIT);
        state_d = ST_SETTLE;
      end

      ST_NEXT: begin
        if (lane_q == LANE_W'(NBITS - 1)) begin
          aligned_d = &lane_ok_q;
          state_d   = ST_DONE;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          wait_d  = WAIT_W'(SLIP_WAIT);
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      wait_q      <= '0;
      match_cnt_q <= '0;
      lane_ok_q   <= '0;
      slip_cnt_q  <= '0;
      aligned_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      wait_q      <= wait_d;
      match_cnt_q <= match_cnt_d;
      lane_ok_q   <= lane_ok_d;
      slip_cnt_q  <= slip_cnt_d;
      aligned_q   <= aligned_d;
    end
  end

  // Gated by rst_i so a reset landing on a SLIP cycle kills the pulse at once.
  assign bitslip_o    = (state_q == ST_SLIP && !rst_i) ? (NBITS'(1) << lane_q) : '0;
  assign busy_o       = (state_q == ST_SETTLE) || (state_q == ST_CHECK) ||
                        (state_q == ST_SLIP)   || (state_q == ST_NEXT);
  assign done_o       = (state_q == ST_DONE);
  assign lane_ok_o    = lane_ok_q;
  assign aligned_o    = aligned_q;
  assign slip_count_o = slip_cnt_q;

endmodule
